dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port word data memory (sync write, comb read) between two requesters:
//  port 0 = core load/store unit, port 1 = debug/DMA. Round-robin arbitration, valid/ready
//  request handshake, byte-enable writes via read-modify-write. Sits between requesters and dmem.
// PARAMETERS
//  ADDR_W     32   byte address width
//  DATA_W     32   data width; fixed 32 (4 byte enables)
//  MEM_WORDS  256  words in dmem; byte addr >= MEM_WORDS*4 is out of range
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       asynchronous reset, active high
//  reqN_valid    in   1       N=0,1: request present
//  reqN_ready    out  1       N=0,1: request accepted this cycle
//  reqN_we       in   1       1=write, 0=read
//  reqN_be       in   4       write byte enables; ignored on reads
//  reqN_addr     in   ADDR_W  byte address; bits[1:0] ignored
//  reqN_wdata    in   DATA_W  write data, byte lanes aligned to be
//  rspN_valid    out  1       N=0,1: one-cycle response pulse
//  rsp_rdata     out  DATA_W  read data, valid with rspN_valid
//  rsp_err       out  1       out-of-range flag, valid with rspN_valid
//  mem_we        out  1       to dmem.we
//  mem_addr      out  ADDR_W  to dmem.addr, word aligned
//  mem_wdata     out  DATA_W  to dmem.wdata
//  mem_rdata     in   DATA_W  from dmem.rdata (combinational)
// BEHAVIOUR
//  - Reset (async): state IDLE, last_grant=1; all outputs 0 (ready forced 0 while rst high).
//  - FSM: IDLE -> ACCESS -> [MERGE] -> RESP -> IDLE. Requests accepted only in IDLE.
//  - IDLE: reqN_ready comb = grant. One valid -> grant it. Both valid -> grant port != last_grant
//    (port 0 first after reset). On handshake latch port, we, be, {addr[31:2],2'b00}, wdata;
//    update last_grant; -> ACCESS. No valid -> stay IDLE, mem_we=0.
//  - ACCESS: mem_addr = latched addr.
//    * out of range: no mem_we, rsp_err<=1, rsp_rdata<=0 -> RESP.
//    * read: rsp_rdata<=mem_rdata -> RESP.
//    * write be=4'b1111: mem_we=1, mem_wdata=wdata -> RESP.
//    * write be=4'b0000: no-op, mem_we=0 -> RESP.
//    * write partial be: merged<= byte-wise be?wdata:mem_rdata -> MERGE.
//  - MERGE: mem_we=1, mem_wdata=merged, same addr -> RESP.
//  - RESP: rsp<port>_valid=1 for exactly one cycle; no backpressure (requester must sink)
//    -> IDLE. rsp_rdata/rsp_err hold until next response; rsp_err=0 for in-range.
//  - Latency from handshake cycle N: read/full/no-op write rsp at N+2; partial write N+3.
//    Throughput: one request per 3 cycles (4 for partial). Write data visible at cycle after mem_we.
//  - mem_we asserted only in ACCESS (full write) or MERGE; never both ports' rsp_valid same cycle.
//  - Requester must hold valid/fields until ready; dropping valid before ready is legal (no grant).
//  - rst mid-operation: FSM -> IDLE immediately, pending mem_we and response dropped,
//    memory word unchanged if reset hits before MERGE edge.
// TESTING
//  1. P0 write addr 0 be=1111 ADCEAFCD; P0 read addr 0 -> rsp0_valid at N+2, rdata ADCEAFCD, err 0.
//  2. Addr 0=ADCEAFCD; P1 write be=0010 wdata 00005500 -> rsp1 at N+3; read 0 -> ADCE55CD.
//  3. After reset P0,P1 valid same cycle, held -> grants P0,P1,P0,P1; rsp pulses alternate.
//  4. MEM_WORDS=256, P0 read addr 0x400 -> rsp_err=1, rdata 0; mem_we never high.
//  5. Partial write, rst high during MERGE -> mem_we 0, no rsp, word unchanged; next grant P0.
//  6. Addr 4=DECFECDA; read addr 6 -> mem_addr 4, rdata DECFECDA; write be=0000 -> rsp, no mem_we.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of requester handshake, response and dmem signals around dmem_arbiter.
// The arbiter takes the slave view; whoever drives the requests and models dmem takes master.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req0_ready;
  logic              req0_we;
  logic [3:0]        req0_be;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;

  logic              req1_valid;
  logic              req1_ready;
  logic              req1_we;
  logic [3:0]        req1_be;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;

  logic              rsp0_valid;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0_valid, req0_we, req0_be, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_be, req1_addr, req1_wdata,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_rdata, rsp_err,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req0_valid, req0_we, req0_be, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_be, req1_addr, req1_wdata,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_rdata, rsp_err,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port word dmem between the core LSU (port 0)
// and debug/DMA (port 1); partial-byte writes become a read-modify-write.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | accepting requests, ready driven combinationally from grant
// S_ACCESS | latched word addressed; read captured or full write issued
// S_MERGE  | merged word from partial write written back
// S_RESP   | one-cycle response pulse on the granted port
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 256
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_WORDS * 4);
  localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(3);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_MERGE  = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] merged_q, merged_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              grant_vld;
  logic              grant_port;
  logic              in_range;
  logic              full_write;
  logic              partial_write;
  logic [DATA_W-1:0] merged_word;

  // On contention the port that did not win last time goes first.
  always_comb begin
    grant_vld  = bus.req0_valid | bus.req1_valid;
    grant_port = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_port = ~last_grant_q;
    end else if (bus.req1_valid) begin
      grant_port = 1'b1;
    end
  end

  always_comb begin
    in_range      = (addr_q < ADDR_LIMIT);
    full_write    = we_q && (be_q == 4'b1111);
    partial_write = we_q && (be_q != 4'b1111) && (be_q != 4'b0000);
    merged_word   = bus.mem_rdata;
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) begin
        merged_word[8*i +: 8] = wdata_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (in_range && partial_write) begin
          state_d = S_MERGE;
        end else begin
          state_d = S_RESP;
        end
      end
      S_MERGE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    port_d       = port_q;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    merged_d     = merged_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          port_d       = grant_port;
          last_grant_d = grant_port;
          if (grant_port) begin
            we_d    = bus.req1_we;
            be_d    = bus.req1_be;
            addr_d  = bus.req1_addr & WORD_MASK;
            wdata_d = bus.req1_wdata;
          end else begin
            we_d    = bus.req0_we;
            be_d    = bus.req0_be;
            addr_d  = bus.req0_addr & WORD_MASK;
            wdata_d = bus.req0_wdata;
          end
        end
      end
      S_ACCESS: begin
        if (!in_range) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          rsp_err_d = 1'b0;
          if (!we_q) begin
            rsp_rdata_d = bus.mem_rdata;
          end else if (partial_write) begin
            merged_d = merged_word;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      be_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      merged_q     <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      we_q         <= we_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      merged_q     <= merged_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Ready is gated by rst so nothing can be accepted while reset is asserted.
  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rst && grant_vld) begin
          bus.req0_ready = ~grant_port;
          bus.req1_ready = grant_port;
        end
      end
      S_ACCESS: begin
        bus.mem_addr = addr_q;
        if (in_range && full_write) begin
          bus.mem_we    = 1'b1;
          bus.mem_wdata = wdata_q;
        end
      end
      S_MERGE: begin
        bus.mem_addr  = addr_q;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = merged_q;
      end
      S_RESP: begin
        bus.rsp0_valid = ~port_q;
        bus.rsp1_valid = port_q;
      end
      default: ;
    endcase
  end

  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
